// File: rtl/lbp_hist_pkg.sv
// Shared types and constants for the LBP histogram block.
// The border helper is only referenced when LBP_HIST_BORDER_FILTER_EN is defined.
package lbp_pkg;

    localparam int IMG_W_DEFAULT = 128;
    localparam int IMG_H_DEFAULT = 128;
    localparam int LBP_CODE_W    = 8;
    localparam int NUM_BINS      = 256;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Row/col come from shift and mask, so the image width must be a power of two.
    function automatic logic is_border(input logic [31:0] addr,
                                       input int unsigned w_log2,
                                       input logic [31:0] img_h);
        logic [31:0] row;
        logic [31:0] col;
        logic [31:0] col_max;
        col_max = (32'd1 << w_log2) - 32'd1;
        row     = addr >> w_log2;
        col     = addr & col_max;
        return (row == 32'd0) || (row == img_h - 32'd1) ||
               (col == 32'd0) || (col == col_max);
    endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Sample stream, finish strobe and histogram output port of lbp_hist.
// border_cnt exists only when LBP_HIST_BORDER_FILTER_EN is defined.
interface lbp_hist_if #(
    parameter int CNT_W  = 15,
    parameter int ADDR_W = 14
);
    import lbp_pkg::*;

    logic                  lbp_valid;
    logic [ADDR_W-1:0]     lbp_addr;
    logic [LBP_CODE_W-1:0] lbp_data;
    logic                  finish;
    logic                  hist_valid;
    logic                  hist_ready;
    logic [LBP_CODE_W-1:0] hist_bin;
    logic [CNT_W-1:0]      hist_count;
    logic                  hist_last;
    logic                  hist_done;
    logic                  drop_err;
    logic [CNT_W-1:0]      sample_cnt;
`ifdef LBP_HIST_BORDER_FILTER_EN
    logic [CNT_W-1:0]      border_cnt;
`endif

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_last, hist_done,
               drop_err, sample_cnt
`ifdef LBP_HIST_BORDER_FILTER_EN
        , output border_cnt
`endif
    );

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_last, hist_done,
               drop_err, sample_cnt
`ifdef LBP_HIST_BORDER_FILTER_EN
        , input border_cnt
`endif
    );

endinterface

// File: rtl/lbp_hist_mem.sv
// 256-entry bin register array: saturating increment port, clear port and async read port.
// Increment and clear are never active together in practice; if they hit one bin, clear wins.
module lbp_hist_mem
    import lbp_pkg::*;
#(
    parameter int CNT_W = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_inc_en,
    input  logic [LBP_CODE_W-1:0] i_inc_idx,
    input  logic                  i_clr_en,
    input  logic [LBP_CODE_W-1:0] i_clr_idx,
    input  logic [LBP_CODE_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]      o_rd_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_bins [NUM_BINS];
    logic [CNT_W-1:0] w_inc_cur;
    logic [CNT_W-1:0] w_inc_sum;

    assign w_inc_cur = r_bins[i_inc_idx];
    assign w_inc_sum = (w_inc_cur == CNT_MAX) ? CNT_MAX : w_inc_cur + CNT_W'(1);
    assign o_rd_data = r_bins[i_rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            if (i_inc_en) begin
                r_bins[i_inc_idx] <= w_inc_sum;
            end
            if (i_clr_en) begin
                r_bins[i_clr_idx] <= '0;
            end
        end
    end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates a frame, streams 256 bins on finish, clears bins as they go.
// Define LBP_HIST_BORDER_FILTER_EN to discard border-pixel samples and count them in border_cnt.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    parameter int CNT_W = 15
) (
    input  logic       clk,
    input  logic       reset,
    lbp_hist_if.slave  bus
);

    localparam int               ADDR_W  = $clog2(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_finish_d;
    logic                  r_hist_valid;
    logic [LBP_CODE_W-1:0] r_hist_bin;
    logic [CNT_W-1:0]      r_hist_count;
    logic                  r_hist_last;
    logic                  r_hist_done;
    logic                  r_drop_err;
    logic [CNT_W-1:0]      r_sample_cnt;

    logic [ADDR_W-1:0]     w_addr;
    logic                  w_border;
    logic                  w_finish_rise;
    logic                  w_sample;
    logic                  w_accept;
    logic                  w_enter_dump;
    logic                  w_last_accept;
    logic [LBP_CODE_W-1:0] w_rd_idx;
    logic [CNT_W-1:0]      w_rd_data;
    logic [CNT_W-1:0]      w_first_count;

    assign w_addr = bus.lbp_addr;

`ifdef LBP_HIST_BORDER_FILTER_EN
    localparam int W_LOG2 = $clog2(IMG_W);

    logic             w_border_hit;
    logic [CNT_W-1:0] r_border_cnt;

    assign w_border     = is_border(32'(w_addr), W_LOG2, 32'(IMG_H));
    assign w_border_hit = (r_state == ACCUM) && bus.lbp_valid && w_border;
    assign bus.border_cnt = r_border_cnt;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^w_addr;
    assign w_border      = 1'b0;
`endif

    assign w_finish_rise = bus.finish && !r_finish_d;
    assign w_sample      = (r_state == ACCUM) && bus.lbp_valid && !w_border;
    assign w_accept      = r_hist_valid && bus.hist_ready;

    // During DUMP the read port looks one bin ahead so the next count is ready at acceptance.
    assign w_rd_idx = (r_state == DUMP) ? r_hist_bin + 8'd1 : '0;

    // Bin 0 is loaded on the same edge that may still increment it, so forward that increment.
    assign w_first_count = (w_sample && (bus.lbp_data == '0) && (w_rd_data != CNT_MAX))
                           ? w_rd_data + CNT_W'(1) : w_rd_data;

    lbp_hist_mem #(
        .CNT_W (CNT_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_inc_en  (w_sample),
        .i_inc_idx (bus.lbp_data),
        .i_clr_en  (w_accept),
        .i_clr_idx (r_hist_bin),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_enter_dump  = 1'b0;
        w_last_accept = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_finish_rise) begin
                    w_state_next = DUMP;
                    w_enter_dump = 1'b1;
                end
            end
            DUMP: begin
                if (w_accept && (r_hist_bin == 8'hFF)) begin
                    w_state_next  = DONE;
                    w_last_accept = 1'b1;
                end
            end
            DONE: begin
                w_state_next = ACCUM;
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_finish_d   <= 1'b0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
            r_hist_last  <= 1'b0;
            r_hist_done  <= 1'b0;
            r_drop_err   <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_finish_d  <= bus.finish;
            r_hist_done <= 1'b0;
            if (bus.lbp_valid && (r_state != ACCUM)) begin
                r_drop_err <= 1'b1;
            end
            if (r_state == DONE) begin
                r_sample_cnt <= '0;
            end else if (w_sample && (r_sample_cnt != CNT_MAX)) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
            if (w_enter_dump) begin
                r_hist_valid <= 1'b1;
                r_hist_bin   <= '0;
                r_hist_count <= w_first_count;
                r_hist_last  <= 1'b0;
            end else if (w_last_accept) begin
                r_hist_valid <= 1'b0;
                r_hist_bin   <= '0;
                r_hist_count <= '0;
                r_hist_last  <= 1'b0;
                r_hist_done  <= 1'b1;
            end else if (w_accept) begin
                r_hist_bin   <= r_hist_bin + 8'd1;
                r_hist_count <= w_rd_data;
                r_hist_last  <= (r_hist_bin == 8'hFE);
            end
        end
    end

`ifdef LBP_HIST_BORDER_FILTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_border_cnt <= '0;
        end else if (r_state == DONE) begin
            r_border_cnt <= '0;
        end else if (w_border_hit && (r_border_cnt != CNT_MAX)) begin
            r_border_cnt <= r_border_cnt + CNT_W'(1);
        end
    end
`endif

    assign bus.hist_valid = r_hist_valid;
    assign bus.hist_bin   = r_hist_bin;
    assign bus.hist_count = r_hist_count;
    assign bus.hist_last  = r_hist_last;
    assign bus.hist_done  = r_hist_done;
    assign bus.drop_err   = r_drop_err;
    assign bus.sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: a bin model feeds a scoreboard queue that is drained on each dump handshake.
// A second instance with CNT_W=4 covers bin and sample counter saturation.
module tb_lbp_hist;
    import lbp_pkg::*;

    localparam int MAXC = 32767;

    typedef struct {
        logic [7:0]  bin;
        logic [31:0] count;
        logic        last;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   model [256];
    int   modelSamples;
`ifdef LBP_HIST_BORDER_FILTER_EN
    int   modelBorder;
`endif
    exp_t sbq [$];

    lbp_hist_if #(.CNT_W(15), .ADDR_W(14)) bus ();
    lbp_hist_if #(.CNT_W(4),  .ADDR_W(14)) bus4 ();

    lbp_hist #(.IMG_W(128), .IMG_H(128), .CNT_W(15)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    lbp_hist #(.IMG_W(128), .IMG_H(128), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, bus.hist_valid, 0);
        checkOutput({tag, "_last"},  bus.hist_last, 0);
        checkOutput({tag, "_done"},  bus.hist_done, 0);
        checkOutput({tag, "_drop"},  bus.drop_err, 0);
        checkOutput({tag, "_bin"},   bus.hist_bin, 0);
        checkOutput({tag, "_count"}, bus.hist_count, 0);
        checkOutput({tag, "_scnt"},  bus.sample_cnt, 0);
`ifdef LBP_HIST_BORDER_FILTER_EN
        checkOutput({tag, "_bcnt"},  bus.border_cnt, 0);
`endif
    endtask

    task automatic clearModel();
        for (int b = 0; b < 256; b++) model[b] = 0;
        modelSamples = 0;
`ifdef LBP_HIST_BORDER_FILTER_EN
        modelBorder = 0;
`endif
    endtask

    task automatic modelSample(input logic [7:0] code, input logic [13:0] addr);
        bit isBorder;
        int a;
        isBorder = 0;
        a = int'(addr);
`ifdef LBP_HIST_BORDER_FILTER_EN
        isBorder = (a / 128 == 0) || (a / 128 == 127) || (a % 128 == 0) || (a % 128 == 127);
        if (isBorder && modelBorder < MAXC) modelBorder++;
`endif
        if (!isBorder) begin
            if (model[code] < MAXC) model[code]++;
            if (modelSamples < MAXC) modelSamples++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic [13:0] addr, input bit counted);
        @(negedge clk);
        bus.lbp_valid = 1'b1;
        bus.lbp_data  = code;
        bus.lbp_addr  = addr;
        if (counted) modelSample(code, addr);
    endtask

    task automatic endStimulus();
        @(negedge clk);
        bus.lbp_valid = 1'b0;
    endtask

    task automatic pulseFinish(input bit withSample, input logic [7:0] code);
        exp_t e;
        @(negedge clk);
        bus.finish = 1'b1;
        if (withSample) begin
            bus.lbp_valid = 1'b1;
            bus.lbp_data  = code;
            bus.lbp_addr  = 14'd300;
            modelSample(code, 14'd300);
        end else begin
            bus.lbp_valid = 1'b0;
        end
        for (int b = 0; b < 256; b++) begin
            e.bin   = 8'(b);
            e.count = 32'(model[b]);
            e.last  = (b == 255);
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.finish    = 1'b0;
        bus.lbp_valid = 1'b0;
        checkOutput("dump_entry_valid", bus.hist_valid, 1);
        checkOutput("frame_sample_cnt", bus.sample_cnt, modelSamples);
`ifdef LBP_HIST_BORDER_FILTER_EN
        checkOutput("frame_border_cnt", bus.border_cnt, modelBorder);
`endif
        clearModel();
    endtask

    task automatic runDump(input logic [3:0] pat, input int abortAt);
        int         hs;
        int         doneSeen;
        bit         stalled;
        bit         aborted;
        logic [7:0] heldBin;
        logic [14:0] heldCount;
        exp_t       e;
        hs = 0; doneSeen = 0; stalled = 0; aborted = 0; heldBin = 0; heldCount = 0;
        for (int cyc = 0; cyc < 3000 && hs < 256; cyc++) begin
            @(negedge clk);
            if (hs == abortAt) begin
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (stalled) begin
                checkOutput("hold_valid", bus.hist_valid, 1);
                checkOutput("hold_bin", bus.hist_bin, heldBin);
                checkOutput("hold_count", bus.hist_count, heldCount);
            end
            bus.hist_ready = pat[cyc % 4];
            if (bus.hist_valid && bus.hist_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb_underflow", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("bin_index", bus.hist_bin, e.bin);
                    checkOutput("bin_count", bus.hist_count, e.count);
                    checkOutput("bin_last", bus.hist_last, e.last);
                end
                hs++;
            end
            stalled   = bus.hist_valid && !bus.hist_ready;
            heldBin   = bus.hist_bin;
            heldCount = bus.hist_count;
        end
        if (aborted) begin
            #1;
            checkResetState("abort");
            @(negedge clk);
            reset = 1'b1;
            bus.hist_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.hist_done || bus.hist_valid) doneSeen++;
            end
            checkOutput("abort_no_done", doneSeen, 0);
            sbq.delete();
            clearModel();
        end else begin
            checkOutput("handshakes", hs, 256);
            @(negedge clk);
            bus.hist_ready = 1'b0;
            checkOutput("done_pulse", bus.hist_done, 1);
            checkOutput("valid_drop", bus.hist_valid, 0);
            @(negedge clk);
            checkOutput("done_end", bus.hist_done, 0);
            checkOutput("cnt_cleared", bus.sample_cnt, 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clearModel();
        bus.lbp_valid  = 1'b0; bus.lbp_addr  = '0; bus.lbp_data  = '0;
        bus.finish     = 1'b0; bus.hist_ready = 1'b0;
        bus4.lbp_valid = 1'b0; bus4.lbp_addr = '0; bus4.lbp_data = '0;
        bus4.finish    = 1'b0; bus4.hist_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] saturation on the CNT_W=4 instance");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus4.lbp_valid = 1'b1; bus4.lbp_data = 8'h00; bus4.lbp_addr = 14'd129;
        end
        @(negedge clk);
        bus4.lbp_valid = 1'b0; bus4.finish = 1'b1;
        @(negedge clk);
        bus4.finish = 1'b0;
        checkOutput("sat_valid", bus4.hist_valid, 1);
        checkOutput("sat_bin", bus4.hist_bin, 0);
        checkOutput("sat_count", bus4.hist_count, 15);
        checkOutput("sat_scnt", bus4.sample_cnt, 15);
        bus4.hist_ready = 1'b1;
        @(negedge clk);
        checkOutput("sat_next_bin", bus4.hist_bin, 1);
        checkOutput("sat_next_count", bus4.hist_count, 0);

        $display("[TB] five samples of 0x3C");
        for (int i = 0; i < 5; i++) applyStimulus(8'h3C, 14'd300, 1'b1);
        pulseFinish(1'b0, 8'h00);
        runDump(4'b1111, -1);

        $display("[TB] full frame of 0xFF");
        for (int i = 0; i < 16384; i++) applyStimulus(8'hFF, 14'(i), 1'b1);
        pulseFinish(1'b0, 8'h00);
        runDump(4'b1111, -1);

        $display("[TB] stalled dump with mixed codes, finish held high");
        for (int i = 0; i < 12; i++) applyStimulus(8'((i * 23) % 256), 14'(400 + i), 1'b1);
        pulseFinish(1'b0, 8'h00);
        @(negedge clk);
        bus.finish = 1'b1;
        runDump(4'b1001, -1);
        repeat (3) @(negedge clk);
        checkOutput("no_retrigger", bus.hist_valid, 0);
        bus.finish = 1'b0;

        $display("[TB] sample dropped during dump");
        applyStimulus(8'h10, 14'd300, 1'b1);
        applyStimulus(8'h10, 14'd300, 1'b1);
        pulseFinish(1'b0, 8'h00);
        applyStimulus(8'h10, 14'd300, 1'b0);
        endStimulus();
        checkOutput("drop_set", bus.drop_err, 1);
        runDump(4'b1111, -1);
        checkOutput("drop_sticky", bus.drop_err, 1);
        applyStimulus(8'h20, 14'd300, 1'b1);
        pulseFinish(1'b1, 8'h00);
        runDump(4'b1101, -1);

        $display("[TB] reset in the middle of a dump");
        applyStimulus(8'h05, 14'd300, 1'b1);
        applyStimulus(8'h05, 14'd300, 1'b1);
        pulseFinish(1'b0, 8'h00);
        runDump(4'b1111, 100);
        for (int i = 0; i < 3; i++) applyStimulus(8'h01, 14'd300, 1'b1);
        pulseFinish(1'b0, 8'h00);
        runDump(4'b1111, -1);

`ifdef LBP_HIST_BORDER_FILTER_EN
        $display("[TB] border filter");
        applyStimulus(8'h07, 14'd0, 1'b1);
        applyStimulus(8'h07, 14'd129, 1'b1);
        applyStimulus(8'h07, 14'd16383, 1'b1);
        applyStimulus(8'h07, 14'd258, 1'b1);
        endStimulus();
        checkOutput("border_cnt_direct", bus.border_cnt, 2);
        checkOutput("border_scnt_direct", bus.sample_cnt, 2);
        pulseFinish(1'b0, 8'h00);
        runDump(4'b1111, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine's output stream.
- Accumulates a 256-bin histogram of lbp_data codes over one 128x128 frame, keyed by code value.
- On the engine's finish, streams all 256 bins out over a valid/ready port to the host/testbench collector.
- Clears bins while streaming, so the block is immediately ready for the next frame.

Parameters:
- IMG_W, 128, image width in pixels (power of 2).
- IMG_H, 128, image height in pixels.
- CNT_W, 15, bin counter width; must hold IMG_W*IMG_H = 16384.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- lbp_valid  in  1  one-cycle strobe, LBP sample present.
- lbp_addr  in  14  pixel address of sample (row*IMG_W+col).
- lbp_data  in  8  LBP code = bin index.
- finish  in  1  engine finished frame (level; rising edge used).
- hist_valid  out  1  bin output valid.
- hist_ready  in  1  downstream accepts bin.
- hist_bin  out  8  bin index being output.
- hist_count  out  CNT_W  count of that bin.
- hist_last  out  1  high with bin 255.
- hist_done  out  1  one-cycle pulse after bin 255 is accepted.
- drop_err  out  1  sticky; sample arrived while not in ACCUM.
- sample_cnt  out  CNT_W  samples accepted in the current frame.

Behaviour:
- Reset (reset=0):
  - All bins = 0, sample_cnt = 0, state = ACCUM.
  - hist_valid, hist_last, hist_done, drop_err = 0; hist_bin = 0, hist_count = 0.
- States: ACCUM, DUMP, DONE.
- ACCUM:
  - Each cycle with lbp_valid=1: bin[lbp_data] increments by 1 at that clock edge, and sample_cnt increments.
  - Back-to-back samples to the same bin must both count (single-cycle read-modify-write on a register array, no hazard).
  - Bins saturate at 2^CNT_W-1; sample_cnt saturates likewise.
  - finish rising edge (finish=1 && finish_d=0) moves to DUMP on the next clock.
  - A sample in the same cycle as the finish rising edge is counted before the transition.
- DUMP:
  - Internal pointer p starts at 0; hist_valid=1, hist_bin=p, hist_count=bin[p], hist_last=(p==255).
  - Outputs are registered and stable while hist_valid && !hist_ready.
  - On hist_valid && hist_ready: bin[p] <= 0, p <= p+1.
  - On acceptance of bin 255: hist_valid drops next cycle, hist_done pulses 1 cycle, state moves to DONE.
  - Throughput: one bin per cycle when hist_ready is held high, so 256 cycles minimum.
  - lbp_valid in DUMP: sample ignored, drop_err <= 1.
- DONE:
  - sample_cnt cleared to 0; next cycle moves to ACCUM.
  - lbp_valid here also sets drop_err.
  - finish still high (level) does not retrigger; only a new rising edge does.
- drop_err is cleared only by reset.
- Mid-operation reset: all state clears asynchronously; a partial dump is abandoned, with no hist_done.
- Address wrap: lbp_addr is not used for binning except by the optional feature; no range check otherwise.

Optional Feature:
- Macro: LBP_HIST_BORDER_FILTER_EN.
- Defined:
  - Samples whose lbp_addr is on the image border are discarded: row 0, row IMG_H-1, col 0, or col IMG_W-1.
  - Row = lbp_addr/IMG_W and col = lbp_addr%IMG_W, computed by shift/mask.
  - Discarded samples increment neither a bin nor sample_cnt.
  - An extra output port border_cnt (CNT_W) counts discarded samples, cleared alongside sample_cnt.
- Undefined: every sample in ACCUM is counted; the border_cnt port is absent.

Decomposition:
- Package lbp_pkg holds:
  - IMG_W/IMG_H defaults, LBP_CODE_W=8, NUM_BINS=256.
  - State enum {ACCUM, DUMP, DONE}.
  - Border-test helper function.
- One natural sub-module: lbp_hist_mem, the 256xCNT_W register array.
  - One increment port, one read-and-clear port, with a saturating adder.
- The top level holds the FSM, finish edge detect, dump handshake and counters.

Test Plan:
- Reset, then 5 samples of code 0x3C on consecutive cycles, then finish pulse, hist_ready=1:
  - bin 0x3C reads 5, all other bins 0.
  - hist_last on bin 255, hist_done 1 cycle later, sample_cnt=5 before clear.
- 16384 samples all code 0xFF, then finish:
  - bin 255 = 16384, no saturation.
  - Forcing CNT_W=4 and 20 samples gives bin = 15.
- Dump with hist_ready toggling 1,0,0,1:
  - hist_bin/hist_count held during stalls, each bin emitted exactly once, 256 handshakes total.
- lbp_valid=1 with code 0x10 during DUMP:
  - drop_err=1 and stays 1, bin 0x10 unaffected.
  - Second frame after DONE starts from all-zero bins.
- Reset asserted at bin 100 of the dump:
  - all outputs return to reset values, no hist_done.
  - A new frame of 3 samples of code 0x01 dumps bin 1 = 3.
- LBP_HIST_BORDER_FILTER_EN with samples at addresses 0, 129, 16383, 258 (all code 0x07):
  - bin 7 = 2, border_cnt = 2, sample_cnt = 2.
